// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, assembles 1- or 2-byte instructions plus an optional
// data operand over an 8-bit read handshake, and holds them for the decoder until retired.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        mem_ack,
  input  logic [15:0] dp,
  input  logic        exec_done,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  input  logic        halt,
  output logic [15:0] inst,
  output logic [7:0]  data,
  output logic        inst_valid,
  output logic [15:0] inst_pc,
  output logic [15:0] pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    StFetchHi,
    StFetchLo,
    StFetchData,
    StReady,
    StHalted
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inst_pc_q, inst_pc_d;
  logic [15:0] inst_q, inst_d;
  logic [7:0]  data_q, data_d;
  logic        fetching;
  logic        data_mode;

  assign fetching = (state_q == StFetchHi) || (state_q == StFetchLo) ||
                    (state_q == StFetchData);

  // Operand-from-data mode is encoded entirely in the opcode (high) byte.
  assign data_mode = (inst_q[15:14] == 2'b10) && (inst_q[10:9] == 2'b01);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_pc_d = inst_pc_q;
    inst_d    = inst_q;
    data_d    = data_q;
    unique case (state_q)
      StFetchHi: begin
        if (mem_ack) begin
          inst_d    = {mem_data, 8'h00};
          data_d    = 8'h00;
          inst_pc_d = pc_q;
          pc_d      = pc_q + 16'd1;
          state_d   = mem_data[7] ? StFetchLo : StReady;
        end
      end
      StFetchLo: begin
        if (mem_ack) begin
          inst_d[7:0] = mem_data;
          pc_d        = pc_q + 16'd1;
          state_d     = data_mode ? StFetchData : StReady;
        end
      end
      StFetchData: begin
        if (mem_ack) begin
          data_d  = mem_data;
          state_d = StReady;
        end
      end
      StReady: begin
        if (exec_done) begin
          if (halt) begin
            state_d = StHalted;
          end else begin
            if (pc_load) pc_d = pc_target;
            state_d = StFetchHi;
          end
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StFetchHi;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetchHi;
      pc_q      <= RESET_PC;
      inst_pc_q <= RESET_PC;
      inst_q    <= 16'h0000;
      data_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_pc_q <= inst_pc_d;
      inst_q    <= inst_d;
      data_q    <= data_d;
    end
  end

  // Reset forces the state to StFetchHi, so the request is also gated by rst_n.
  assign mem_rd     = fetching && rst_n;
  assign mem_addr   = (state_q == StFetchData) ? (dp + {8'h00, inst_q[7:0]}) : pc_q;
  assign inst       = inst_q;
  assign data       = data_q;
  assign inst_valid = (state_q == StReady);
  assign inst_pc    = inst_pc_q;
  assign pc         = pc_q;
  assign halted     = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model (expected request addresses and presented
// instruction per fetch) driven by a randomised memory responder and retire/redirect stimulus.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [15:0] RPC = 16'h0000;

  logic        clk, rst_n;
  logic        mem_rd, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [15:0] dp, pc_target;
  logic        exec_done, pc_load, halt;
  logic [15:0] inst, inst_pc, pc;
  logic [7:0]  data;
  logic        inst_valid, halted;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ack   (mem_ack),
    .dp        (dp),
    .exec_done (exec_done),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .halt      (halt),
    .inst      (inst),
    .data      (data),
    .inst_valid(inst_valid),
    .inst_pc   (inst_pc),
    .pc        (pc),
    .halted    (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0]  mem [65536];
  int          n_pass, n_chk;

  // Model: outstanding request addresses of the current fetch, then the presented result.
  logic [15:0] exp_q[$];
  logic [15:0] e_inst, e_ipc, e_pc;
  logic [7:0]  e_data;
  bit          m_halted;
  int          wait_cnt, cur_wait;
  bit          was_ready;
  logic [15:0] last_addr;

  // Stimulus knobs
  bit          k_rand, k_exec, k_load, k_halt;
  logic [15:0] k_target, k_dp;
  int          k_wait;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic int pick_wait();
    if (k_wait >= 0) return k_wait;
    return ($urandom % 2 == 0) ? 0 : int'($urandom % 4);
  endfunction

  task automatic start_instr(input logic [15:0] a);
    logic [7:0]  b0, b1;
    logic [15:0] a1, da;
    b0 = mem[a];
    a1 = a + 16'd1;
    exp_q.delete();
    exp_q.push_back(a);
    e_ipc  = a;
    e_inst = {b0, 8'h00};
    e_data = 8'h00;
    e_pc   = a1;
    if (b0[7]) begin
      b1 = mem[a1];
      exp_q.push_back(a1);
      e_inst[7:0] = b1;
      e_pc = a1 + 16'd1;
      if (b0[7:6] == 2'b10 && b0[2:1] == 2'b01) begin
        da = dp + {8'h00, b1};
        exp_q.push_back(da);
        e_data = mem[da];
      end
    end
    wait_cnt = 0;
    cur_wait = pick_wait();
  endtask

  // One cycle's compare against the model, then drive inputs for the next rising edge.
  task automatic body();
    bit do_exec;
    exec_done = 1'b0;
    pc_load   = 1'($urandom);
    halt      = 1'($urandom);
    pc_target = 16'($urandom);
    mem_ack   = 1'b0;
    mem_data  = 8'($urandom);
    was_ready = 1'b0;
    if (m_halted) begin
      chk("halted", halted, 1);
      chk("halt_valid", inst_valid, 0);
      chk("halt_rd", mem_rd, 0);
      mem_ack   = 1'($urandom);
      exec_done = 1'($urandom);
    end else if (exp_q.size() != 0) begin
      chk("fetch_rd", mem_rd, 1);
      chk("fetch_valid", inst_valid, 0);
      chk("fetch_addr", mem_addr, exp_q[0]);
      chk("fetch_halted", halted, 0);
      exec_done = 1'($urandom);
      if (wait_cnt >= cur_wait) begin
        mem_ack   = 1'b1;
        mem_data  = mem[mem_addr];
        last_addr = mem_addr;
        void'(exp_q.pop_front());
        wait_cnt = 0;
        cur_wait = pick_wait();
      end else begin
        wait_cnt++;
      end
    end else begin
      was_ready = 1'b1;
      chk("rdy_valid", inst_valid, 1);
      chk("rdy_rd", mem_rd, 0);
      chk("rdy_halted", halted, 0);
      chk("rdy_inst", inst, e_inst);
      chk("rdy_data", data, e_data);
      chk("rdy_inst_pc", inst_pc, e_ipc);
      chk("rdy_pc", pc, e_pc);
      mem_ack = 1'($urandom);
      do_exec = k_rand ? ($urandom % 3 == 0) : k_exec;
      if (do_exec) begin
        exec_done = 1'b1;
        if (k_rand) begin
          halt    = 1'b0;
          pc_load = 1'($urandom);
          dp      = 16'($urandom);
        end else begin
          halt      = k_halt;
          pc_load   = k_load;
          pc_target = k_target;
          dp        = k_dp;
        end
        if (halt) m_halted = 1'b1;
        else start_instr(pc_load ? pc_target : e_pc);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    body();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      n++;
      if (was_ready || m_halted) break;
    end
    if (!was_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic issue(input bit ld, input logic [15:0] tgt, input bit hlt,
                       input logic [15:0] d, input int w);
    k_load = ld; k_target = tgt; k_halt = hlt; k_dp = d; k_wait = w; k_exec = 1'b1;
    step();
    k_exec = 1'b0;
    if (!was_ready) chk("issue_not_ready", 0, 1);
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0; mem_ack = 1'b1; mem_data = 8'hFF;
    exec_done = 1'b1; halt = 1'b1; pc_load = 1'b1;
    #1;
    chk("rst_valid", inst_valid, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_halted", halted, 0);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_data", data, 8'h00);
    chk("rst_pc", pc, RPC);
    chk("rst_inst_pc", inst_pc, RPC);
    repeat (hold) @(negedge clk);
    chk("rst_rd_hold", mem_rd, 0);
    rst_n = 1'b1; mem_ack = 1'b0; exec_done = 1'b0; halt = 1'b0; pc_load = 1'b0;
    m_halted = 1'b0;
    start_instr(RPC);
    #1;
    body();
  endtask

  initial begin
    int n;
    n_pass = 0; n_chk = 0;
    rst_n = 1'b0; mem_ack = 1'b0; mem_data = 8'h00; dp = 16'h0000;
    exec_done = 1'b0; pc_load = 1'b0; halt = 1'b0; pc_target = 16'h0000;
    k_rand = 1'b0; k_exec = 1'b0; k_load = 1'b0; k_halt = 1'b0;
    k_target = 16'h0000; k_dp = 16'h0000; k_wait = 0;
    m_halted = 1'b0; last_addr = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0000] = 8'h01;
    mem[16'h0010] = 8'h88; mem[16'h0011] = 8'h05;
    mem[16'h0020] = 8'h8A; mem[16'h0021] = 8'h03; mem[16'h1003] = 8'h5A;
    mem[16'hFFFF] = 8'h82;

    @(negedge clk);
    do_reset(3);
    wait_ready(n);
    chk("lat_1byte", n, 1);
    chk("t1_inst", inst, 16'h0100);
    chk("t1_inst_pc", inst_pc, 16'h0000);
    chk("t1_pc", pc, 16'h0001);
    chk("t1_rd", mem_rd, 0);

    issue(1'b1, 16'h0010, 1'b0, 16'h0000, 2);
    wait_ready(n);
    chk("lat_2byte_wait2", n, 7);
    chk("t2_inst", inst, 16'h8805);
    chk("t2_data", data, 8'h00);
    chk("t2_pc", pc, 16'h0012);

    issue(1'b1, 16'h0020, 1'b0, 16'h1000, 0);
    wait_ready(n);
    chk("lat_data", n, 4);
    chk("t3_data_addr", last_addr, 16'h1003);
    chk("t3_inst", inst, 16'h8A03);
    chk("t3_data", data, 8'h5A);

    issue(1'b1, 16'h0400, 1'b0, 16'h0000, 1);
    step();
    chk("t4_valid_drop", inst_valid, 0);
    chk("t4_rd", mem_rd, 1);
    chk("t4_addr", mem_addr, 16'h0400);
    wait_ready(n);
    repeat (3) step();  // pc_load pulses here come without exec_done

    mem[16'h0000] = 8'h20;
    issue(1'b1, 16'hFFFF, 1'b0, 16'hFFF0, 0);
    wait_ready(n);
    chk("t5_inst", inst, 16'h8220);
    chk("t5_inst_pc", inst_pc, 16'hFFFF);
    chk("t5_pc_wrap", pc, 16'h0001);
    chk("t5_data_addr", last_addr, 16'h0010);
    chk("t5_data", data, 8'h88);

    k_rand = 1'b1; k_wait = -1;
    for (int i = 0; i < 3000; i++) step();
    k_rand = 1'b0;

    wait_ready(n);
    issue(1'b1, 16'h1234, 1'b1, 16'h0000, 0);
    repeat (10) step();
    chk("t6_halted", halted, 1);
    chk("t6_rd", mem_rd, 0);

    mem[16'h0000] = 8'h90;
    k_wait = 2;
    do_reset(2);
    repeat (3) step();
    chk("t7_in_lo", mem_addr, 16'h0001);
    k_wait = 0;
    do_reset(2);
    wait_ready(n);
    chk("t7_lat", n, 2);
    chk("t7_inst_hi", inst[15:8], 8'h90);
    chk("t7_inst_pc", inst_pc, 16'h0000);
    chk("t7_pc", pc, 16'h0002);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
